addsub_serial: RTL and testbench

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, from LSB digit to MSB digit. It keeps the existing add/sub convention: b is XOR-inverted by b_invert, and the carry-in is in_carry XOR b_invert. It also adds a valid/ready handshake, registered operands and results, and a full flag set (carry, signed overflow, zero, negative). It sits in the datapath wherever a wide add/sub must trade latency for adder area.

---
 rtl/addsub_serial.sv | 114 +++++++++++
 tb/tb_addsub_serial.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock from LSB to MSB,
// with valid/ready handshakes on both sides and registered result plus flags.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_carry,
    input  logic             b_invert,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bf_reg;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] out_reg;
    logic             carry_flag;
    logic             ovf_flag;
    logic             zero_flag;
    logic             neg_flag;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] out_next;
    logic             last;

    assign a_dig = a_reg[k*DIGIT +: DIGIT];
    assign b_dig = bf_reg[k*DIGIT +: DIGIT];
    assign dsum  = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry);
    assign last  = (k == KW'(N - 1));

    // Result vector as it will look once the current digit is written;
    // the flags on the final digit are taken from this complete value.
    always_comb begin
        out_next = out_reg;
        out_next[k*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            bf_reg     <= '0;
            carry      <= 1'b0;
            k          <= '0;
            out_reg    <= '0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        bf_reg <= b ^ {WIDTH{b_invert}};
                        carry  <= in_carry ^ b_invert;
                        k      <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out_reg <= out_next;
                    carry   <= dsum[DIGIT];
                    k       <= k + KW'(1);
                    if (last) begin
                        carry_flag <= dsum[DIGIT];
                        ovf_flag   <= (a_reg[WIDTH-1] == bf_reg[WIDTH-1]) &&
                                      (out_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero_flag  <= (out_next == '0);
                        neg_flag   <= out_next[WIDTH-1];
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_reg;
    assign out_carry = carry_flag;
    assign overflow  = ovf_flag;
    assign zero      = zero_flag;
    assign negative  = neg_flag;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: four instances at WIDTH=8 with DIGIT=1,2,4,8,
// checked against an integer-arithmetic reference model.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] in_valid_v;
    logic [3:0] out_ready_v;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_carry;
    logic       b_invert;
    logic [3:0] in_ready_v;
    logic [3:0] out_valid_v;
    logic [3:0] out_carry_v;
    logic [3:0] overflow_v;
    logic [3:0] zero_v;
    logic [3:0] negative_v;
    logic [7:0] out_v [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        addsub_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a),
            .b         (b),
            .in_carry  (in_carry),
            .b_invert  (b_invert),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out       (out_v[g]),
            .out_carry (out_carry_v[g]),
            .overflow  (overflow_v[g]),
            .zero      (zero_v[g]),
            .negative  (negative_v[g])
        );
    end

    // Reference: plain integer arithmetic, overflow from the signed range.
    function automatic void model(input int av, input int bv, input int ci, input int bi,
                                  output logic [7:0] o, output logic c, output logic v,
                                  output logic z, output logic n);
        int bf, cin, tot, sa, sb, st;
        bf  = bi ? (255 - bv) : bv;
        cin = ci ^ bi;
        tot = av + bf + cin;
        o   = 8'(tot % 256);
        c   = (tot >= 256);
        sa  = (av >= 128) ? av - 256 : av;
        sb  = (bf >= 128) ? bf - 256 : bf;
        st  = sa + sb + cin;
        v   = (st > 127) || (st < -128);
        z   = ((tot % 256) == 0);
        n   = ((tot % 256) >= 128);
    endfunction

    // Issues one operation on instance idx, checks latency and results;
    // optionally releases it with a one-cycle out_ready pulse.
    task automatic do_op(input int idx, input int av, input int bv, input int ci,
                         input int bi, input bit release_it);
        logic [7:0] eo;
        logic ec, ev, ez, en;
        int nd, edges;
        nd = 8 >> idx;
        model(av, bv, ci, bi, eo, ec, ev, ez, en);
        @(negedge clk);
        checks++;
        if (in_ready_v[idx] !== 1'b1) begin
            errors++;
            $display("FAIL op_ready[%0d]: in_ready=%b expected 1", idx, in_ready_v[idx]);
        end
        a = 8'(av); b = 8'(bv); in_carry = ci[0]; b_invert = bi[0];
        in_valid_v[idx] = 1'b1;
        @(posedge clk);
        #1 in_valid_v[idx] = 1'b0;
        edges = 1;
        while (out_valid_v[idx] !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1 edges++;
        end
        checks++;
        if (edges != nd + 1) begin
            errors++;
            $display("FAIL latency[%0d]: edges=%0d expected %0d", idx, edges, nd + 1);
        end
        @(negedge clk);
        checks++;
        if (out_v[idx] !== eo || out_carry_v[idx] !== ec || overflow_v[idx] !== ev ||
            zero_v[idx] !== ez || negative_v[idx] !== en) begin
            errors++;
            $display("FAIL result[%0d] a=%02h b=%02h ci=%0d bi=%0d: out=%02h c=%b v=%b z=%b n=%b expected %02h %b %b %b %b",
                     idx, av, bv, ci, bi, out_v[idx], out_carry_v[idx], overflow_v[idx],
                     zero_v[idx], negative_v[idx], eo, ec, ev, ez, en);
        end
        if (release_it) begin
            out_ready_v[idx] = 1'b1;
            @(posedge clk);
            #1 out_ready_v[idx] = 1'b0;
            checks++;
            if (in_ready_v[idx] !== 1'b1 || out_valid_v[idx] !== 1'b0) begin
                errors++;
                $display("FAIL release[%0d]: in_ready=%b out_valid=%b expected 1 0",
                         idx, in_ready_v[idx], out_valid_v[idx]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || out_v[i] !== 8'h00 ||
                out_carry_v[i] !== 1'b0 || overflow_v[i] !== 1'b0 || zero_v[i] !== 1'b0 ||
                negative_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: rdy=%b vld=%b out=%02h flags=%b%b%b%b expected 1 0 00 0000",
                         i, in_ready_v[i], out_valid_v[i], out_v[i], out_carry_v[i],
                         overflow_v[i], zero_v[i], negative_v[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        do_op(1, 'h7F, 'h01, 0, 0, 1);
        do_op(1, 'h05, 'h05, 0, 1, 1);
        do_op(1, 'h00, 'h01, 0, 1, 1);
        do_op(1, 'hFF, 'h01, 0, 0, 1);
        do_op(1, 'h40, 'h10, 1, 1, 1);
    endtask

    task automatic test_backpressure();
        logic [7:0] so;
        logic [3:0] sf;
        do_op(1, 'h9C, 'h3B, 1, 0, 0);
        so = out_v[1];
        sf = {out_carry_v[1], overflow_v[1], zero_v[1], negative_v[1]};
        a = 8'h11; b = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid_v[1] = (i >= 3 && i <= 5);
            checks++;
            if (out_valid_v[1] !== 1'b1 || in_ready_v[1] !== 1'b0 || out_v[1] !== so ||
                {out_carry_v[1], overflow_v[1], zero_v[1], negative_v[1]} !== sf) begin
                errors++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b out=%02h expected 1 0 %02h",
                         i, out_valid_v[1], in_ready_v[1], out_v[1], so);
            end
        end
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b1;
        @(posedge clk);
        #1 out_ready_v[1] = 1'b0;
        checks++;
        if (in_ready_v[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b expected 1", in_ready_v[1]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_no_accept[%0d]: vld=%b rdy=%b expected 0 1",
                         i, out_valid_v[1], in_ready_v[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_op(1, 'h7F, 'h01, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1 || out_v[1] !== 8'h00 ||
            {out_carry_v[1], overflow_v[1], zero_v[1], negative_v[1]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_done: vld=%b rdy=%b out=%02h flags=%b%b%b%b expected 0 1 00 0000",
                     out_valid_v[1], in_ready_v[1], out_v[1], out_carry_v[1],
                     overflow_v[1], zero_v[1], negative_v[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        a = 8'hFF; b = 8'h7F; in_carry = 1'b0; b_invert = 1'b0;
        in_valid_v[1] = 1'b1;
        @(posedge clk);
        #1 in_valid_v[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1 || out_v[1] !== 8'h00) begin
            errors++;
            $display("FAIL reset_run: vld=%b rdy=%b out=%02h expected 0 1 00",
                     out_valid_v[1], in_ready_v[1], out_v[1]);
        end
        @(negedge clk);
        reset = 1'b0;
        do_op(1, 'h10, 'h20, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int cyc, n_acc, last_acc, vld_run;
        cyc = 0; n_acc = 0; last_acc = -1; vld_run = 0;
        a = 8'h03; b = 8'h04; in_carry = 1'b0; b_invert = 1'b0;
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        in_valid_v[1] = 1'b1;
        while (n_acc < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (in_ready_v[1] === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++;
                        $display("FAIL issue_interval: %0d cycles expected 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid_v[1] === 1'b1) begin
                vld_run++;
                checks++;
                if (out_v[1] !== 8'h07 || vld_run != 1) begin
                    errors++;
                    $display("FAIL b2b_out: out=%02h run=%0d expected 07 1", out_v[1], vld_run);
                end
            end else begin
                vld_run = 0;
            end
        end
        checks++;
        if (n_acc < 4) begin
            errors++;
            $display("FAIL b2b_timeout: accepts=%0d expected 4", n_acc);
        end
        in_valid_v[1] = 1'b0;
        repeat (10) @(negedge clk);
        out_ready_v[1] = 1'b0;
    endtask

    task automatic test_sweep();
        for (int idx = 0; idx < 4; idx++) begin
            do_op(idx, 'h80, 'h80, 0, 0, 1);
            for (int i = 0; i < 15; i++) begin
                do_op(idx, int'($urandom_range(255)), int'($urandom_range(255)),
                      int'($urandom_range(1)), int'($urandom_range(1)), 1);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid_v = '0;
        out_ready_v = '0;
        a = '0; b = '0; in_carry = 1'b0; b_invert = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
